// File: rtl/ncpu32k_bpu_bht_ctrl.sv
// ncpu32k_bpu_bht_ctrl
//   Controller for the branch history table (BHT) behind the BPU direction
//   predictor. It owns a single-ported table of 2-bit saturating counters.
//   After reset it sweeps the whole table to 2'b01 (weakly not-taken). It then
//   shares the one table port between fetch-side lookups and writeback-side
//   read-modify-write updates.
//
//   Optional feature macro: NCPU_BPU_STAT_EN
//     When defined, the lookup and mispredict statistics counters are built.
//     When undefined, both statistics ports are tied to 0.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   bpu_rd              lookup request (handshake with bpu_rd_ready)
//   bpu_rd_ready        lookup accepted when bpu_rd & bpu_rd_ready
//   bpu_insn_pc         lookup word PC; the low BHT_AW bits index the table
//   bpu_jmprel          lookup insn is a relative branch
//   bpu_rd_valid        one-cycle pulse, the cycle after an accepted lookup
//   bpu_jmprel_taken    prediction; held until the next accepted lookup
//   bpu_wb              update request (handshake with bpu_wb_ready)
//   bpu_wb_ready        update accepted when bpu_wb & bpu_wb_ready
//   bpu_wb_jmprel       updated insn is a relative branch
//   bpu_wb_insn_pc      update word PC; the low BHT_AW bits index the table
//   bpu_wb_taken        resolved branch outcome
//   bpu_wb_hit          prediction was correct (feeds statistics only)
//   bpu_init_done       table sweep finished; stays high until reset
//   bpu_stat_lookup     count of accepted branch lookups
//   bpu_stat_miss       count of accepted mispredicted branch updates
//
// Handshake: a transfer happens on a rising clk edge where valid (bpu_rd or
// bpu_wb) and the matching ready are both high. The ready signals depend on
// FSM state only, so a requester may hold valid while it waits for ready.

module ncpu32k_bpu_bht_ctrl #(
    parameter int AW     = 32,
    parameter int BHT_AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bpu_rd,
    output logic          bpu_rd_ready,
    input  logic [AW-3:0] bpu_insn_pc,
    input  logic          bpu_jmprel,
    output logic          bpu_rd_valid,
    output logic          bpu_jmprel_taken,
    input  logic          bpu_wb,
    output logic          bpu_wb_ready,
    input  logic          bpu_wb_jmprel,
    input  logic [AW-3:0] bpu_wb_insn_pc,
    input  logic          bpu_wb_taken,
    input  logic          bpu_wb_hit,
    output logic          bpu_init_done,
    output logic [31:0]   bpu_stat_lookup,
    output logic [31:0]   bpu_stat_miss
);

    localparam int DEPTH = 1 << BHT_AW;

    typedef enum logic {
        S_INIT,
        S_RUN
    } top_state_t;

    typedef enum logic [1:0] {
        U_IDLE,
        U_RD,
        U_WR
    } upd_state_t;

    top_state_t        top_state;
    upd_state_t        upd_state;
    logic [BHT_AW-1:0] init_idx;
    logic [BHT_AW-1:0] upd_idx;
    logic              upd_taken;
    logic [1:0]        upd_cnt;
    logic [1:0]        upd_next_cnt;

    logic [1:0]        bht [DEPTH];

    logic              run;
    logic              rd_fire;
    logic              wb_fire;
    logic              wb_qual;
    logic [BHT_AW-1:0] rd_idx;
    logic [BHT_AW-1:0] wb_idx;

    assign run          = (top_state == S_RUN);
    assign bpu_init_done = run;
    // U_RD owns the port for the read half of an update, so nothing is
    // accepted there. In U_WR the port is busy writing, so a lookup must wait,
    // but a new update can be accepted because its read happens next cycle.
    assign bpu_wb_ready = run & (upd_state != U_RD);
    assign bpu_rd_ready = run & (upd_state == U_IDLE);

    assign rd_fire = bpu_rd & bpu_rd_ready;
    assign wb_fire = bpu_wb & bpu_wb_ready;
    // Non-branch updates are consumed without touching the table.
    assign wb_qual = wb_fire & bpu_wb_jmprel;
    assign rd_idx  = bpu_insn_pc[BHT_AW-1:0];
    assign wb_idx  = bpu_wb_insn_pc[BHT_AW-1:0];

    // Saturating counter step applied in U_WR.
    always_comb begin
        upd_next_cnt = upd_cnt;
        if (upd_taken) begin
            if (upd_cnt != 2'b11) upd_next_cnt = upd_cnt + 2'b01;
        end else begin
            if (upd_cnt != 2'b00) upd_next_cnt = upd_cnt - 2'b01;
        end
    end

    // Top sweep FSM and update FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_state <= S_INIT;
            init_idx  <= '0;
            upd_state <= U_IDLE;
            upd_idx   <= '0;
            upd_taken <= 1'b0;
            upd_cnt   <= 2'b00;
        end else begin
            case (top_state)
                S_INIT: begin
                    init_idx <= init_idx + 1'b1;
                    if (&init_idx) top_state <= S_RUN;
                end
                default: begin
                    case (upd_state)
                        U_IDLE: begin
                            if (wb_qual) begin
                                upd_idx   <= wb_idx;
                                upd_taken <= bpu_wb_taken;
                                upd_state <= U_RD;
                            end
                        end
                        U_RD: begin
                            upd_cnt   <= bht[upd_idx];
                            upd_state <= U_WR;
                        end
                        default: begin
                            // The write below commits this edge, so a chained
                            // update to the same entry reads the new value.
                            if (wb_qual) begin
                                upd_idx   <= wb_idx;
                                upd_taken <= bpu_wb_taken;
                                upd_state <= U_RD;
                            end else begin
                                upd_state <= U_IDLE;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    // Table write port: sweep writes during INIT, update writes in U_WR.
    // Reset only restarts the sweep; the storage itself has no reset.
    always_ff @(posedge clk) begin
        if (top_state == S_INIT) begin
            bht[init_idx] <= 2'b01;
        end else if (upd_state == U_WR) begin
            bht[upd_idx] <= upd_next_cnt;
        end
    end

    // Lookup result, registered one cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bpu_rd_valid     <= 1'b0;
            bpu_jmprel_taken <= 1'b0;
        end else begin
            bpu_rd_valid <= rd_fire;
            if (rd_fire) bpu_jmprel_taken <= bpu_jmprel & bht[rd_idx][1];
        end
    end

`ifdef NCPU_BPU_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bpu_stat_lookup <= 32'd0;
            bpu_stat_miss   <= 32'd0;
        end else begin
            if (rd_fire & bpu_jmprel) bpu_stat_lookup <= bpu_stat_lookup + 32'd1;
            if (wb_qual & ~bpu_wb_hit) bpu_stat_miss <= bpu_stat_miss + 32'd1;
        end
    end
`else
    assign bpu_stat_lookup = 32'd0;
    assign bpu_stat_miss   = 32'd0;
`endif

    // PC bits above the table index select nothing here; aliasing is intended.
    logic unused_bits;
    assign unused_bits = ^{bpu_insn_pc[AW-3:BHT_AW], bpu_wb_insn_pc[AW-3:BHT_AW], bpu_wb_hit};

endmodule

// File: tb/tb_ncpu32k_bpu_bht_ctrl.sv
module tb_ncpu32k_bpu_bht_ctrl;

  localparam int AW     = 32;
  localparam int BHT_AW = 6;
  localparam int DEPTH  = 1 << BHT_AW;
  localparam int WAIT_MAX = 100;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          bpu_rd;
  logic          bpu_rd_ready;
  logic [AW-3:0] bpu_insn_pc;
  logic          bpu_jmprel;
  logic          bpu_rd_valid;
  logic          bpu_jmprel_taken;
  logic          bpu_wb;
  logic          bpu_wb_ready;
  logic          bpu_wb_jmprel;
  logic [AW-3:0] bpu_wb_insn_pc;
  logic          bpu_wb_taken;
  logic          bpu_wb_hit;
  logic          bpu_init_done;
  logic [31:0]   bpu_stat_lookup;
  logic [31:0]   bpu_stat_miss;

  always #5 clk = ~clk;

  ncpu32k_bpu_bht_ctrl #(.AW(AW), .BHT_AW(BHT_AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bpu_rd           (bpu_rd),
    .bpu_rd_ready     (bpu_rd_ready),
    .bpu_insn_pc      (bpu_insn_pc),
    .bpu_jmprel       (bpu_jmprel),
    .bpu_rd_valid     (bpu_rd_valid),
    .bpu_jmprel_taken (bpu_jmprel_taken),
    .bpu_wb           (bpu_wb),
    .bpu_wb_ready     (bpu_wb_ready),
    .bpu_wb_jmprel    (bpu_wb_jmprel),
    .bpu_wb_insn_pc   (bpu_wb_insn_pc),
    .bpu_wb_taken     (bpu_wb_taken),
    .bpu_wb_hit       (bpu_wb_hit),
    .bpu_init_done    (bpu_init_done),
    .bpu_stat_lookup  (bpu_stat_lookup),
    .bpu_stat_miss    (bpu_stat_miss)
  );

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad   = 0;
  int model_cnt [DEPTH];
  int model_lookups = 0;
  int model_misses  = 0;
  logic [31:0] exp_q[$];
`ifdef NCPU_BPU_STAT_EN
  bit stat_en = 1'b1;
`else
  bit stat_en = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_cnt[i] = 1;
    model_lookups = 0;
    model_misses  = 0;
  endtask

  function automatic int idx_of(input logic [AW-3:0] pc);
    return int'(pc) % DEPTH;
  endfunction

  task automatic model_update(input logic [AW-3:0] pc, input bit j, input bit t, input bit hit);
    int k;
    if (!j) return;
    k = idx_of(pc);
    if (t) model_cnt[k] = (model_cnt[k] + 1 > 3) ? 3 : model_cnt[k] + 1;
    else   model_cnt[k] = (model_cnt[k] - 1 < 0) ? 0 : model_cnt[k] - 1;
    if (!hit) model_misses++;
  endtask

  task automatic check_stats(input string tag);
    check({tag, " stat_lookup"}, bpu_stat_lookup, stat_en ? 32'(model_lookups) : 32'd0);
    check({tag, " stat_miss"},   bpu_stat_miss,   stat_en ? 32'(model_misses)  : 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic init_sweep_check();
    // Called at the negedge on which rst_n was released.
    for (int i = 0; i < DEPTH; i++) begin
      check("init rd_ready", {31'd0, bpu_rd_ready}, 32'd0);
      check("init wb_ready", {31'd0, bpu_wb_ready}, 32'd0);
      check("init done low", {31'd0, bpu_init_done}, 32'd0);
      @(negedge clk);
    end
    check("init_done after sweep", {31'd0, bpu_init_done}, 32'd1);
    check("rd_ready after sweep",  {31'd0, bpu_rd_ready}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset rd_valid", {31'd0, bpu_rd_valid}, 32'd0);
    check("reset taken",    {31'd0, bpu_jmprel_taken}, 32'd0);
    check("reset init_done", {31'd0, bpu_init_done}, 32'd0);
    check("reset stat_lookup", bpu_stat_lookup, 32'd0);
    check("reset stat_miss",   bpu_stat_miss, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    init_sweep_check();
  endtask

  task automatic do_lookup(input string name, input logic [AW-3:0] pc, input bit j);
    int n = 0;
    @(negedge clk);
    bpu_rd = 1'b1; bpu_insn_pc = pc; bpu_jmprel = j;
    while (!bpu_rd_ready && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    if (!bpu_rd_ready) begin
      check({name, " lookup timeout"}, 32'd1, 32'd0);
      bpu_rd = 1'b0;
      return;
    end
    exp_q.push_back({31'd0, j && (model_cnt[idx_of(pc)] >= 2)});
    if (j) model_lookups++;
    @(posedge clk);
    @(negedge clk);
    bpu_rd = 1'b0;
    check({name, " rd_valid"}, {31'd0, bpu_rd_valid}, 32'd1);
    check({name, " taken"}, {31'd0, bpu_jmprel_taken}, exp_q.pop_front());
  endtask

  task automatic do_update(input logic [AW-3:0] pc, input bit j, input bit t, input bit hit);
    int n = 0;
    @(negedge clk);
    bpu_wb = 1'b1; bpu_wb_insn_pc = pc; bpu_wb_jmprel = j;
    bpu_wb_taken = t; bpu_wb_hit = hit;
    while (!bpu_wb_ready && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    if (!bpu_wb_ready) begin
      check("update timeout", 32'd1, 32'd0);
      bpu_wb = 1'b0;
      return;
    end
    model_update(pc, j, t, hit);
    @(posedge clk);
    @(negedge clk);
    bpu_wb = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit            is_upd;
    logic [AW-3:0] pc;
    bit            j;
    bit            t;
    bit            hit;
    bit            exp_taken;
  } vec_t;

  vec_t vecs [14];

  initial begin
    rst_n = 1'b0;
    bpu_rd = 1'b0; bpu_insn_pc = '0; bpu_jmprel = 1'b0;
    bpu_wb = 1'b0; bpu_wb_insn_pc = '0; bpu_wb_jmprel = 1'b0;
    bpu_wb_taken = 1'b0; bpu_wb_hit = 1'b0;

    // Expected predictions derived by hand from the counter rules.
    vecs[0]  = '{0, 30'd5,  1, 0, 0, 0};  // fresh entry c=1
    vecs[1]  = '{1, 30'd5,  1, 1, 1, 0};  // c=2
    vecs[2]  = '{0, 30'd5,  1, 0, 0, 1};
    vecs[3]  = '{1, 30'd5,  1, 1, 0, 0};  // c=3
    vecs[4]  = '{1, 30'd5,  1, 1, 1, 0};  // saturates at 3
    vecs[5]  = '{1, 30'd5,  1, 0, 0, 0};  // c=2
    vecs[6]  = '{0, 30'd5,  1, 0, 0, 1};
    vecs[7]  = '{0, 30'd5,  0, 0, 0, 0};  // not a branch
    vecs[8]  = '{1, 30'd7,  1, 1, 1, 0};  // back-to-back updates
    vecs[9]  = '{1, 30'd7,  1, 1, 1, 0};  // c=3
    vecs[10] = '{0, 30'd7,  1, 0, 0, 1};
    vecs[11] = '{1, 30'd69, 1, 0, 1, 0};  // aliases entry 5 -> c=1
    vecs[12] = '{0, 30'd5,  1, 0, 0, 0};
    vecs[13] = '{0, 30'd71, 1, 0, 0, 1};  // aliases entry 7, c=3

    model_reset();
    #1;
    check("por rd_valid", {31'd0, bpu_rd_valid}, 32'd0);
    check("por init_done", {31'd0, bpu_init_done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    init_sweep_check();
    check_stats("post reset");

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_upd) begin
        do_update(vecs[i].pc, vecs[i].j, vecs[i].t, vecs[i].hit);
      end else begin
        check($sformatf("vec%0d model", i), {31'd0, vecs[i].j && (model_cnt[idx_of(vecs[i].pc)] >= 2)},
              {31'd0, vecs[i].exp_taken});
        do_lookup($sformatf("vec%0d", i), vecs[i].pc, vecs[i].j);
      end
    end
    check_stats("table");

    // Ready timing around an accepted update; a lookup held from t+1.
    @(negedge clk);
    bpu_wb = 1'b1; bpu_wb_insn_pc = 30'd20; bpu_wb_jmprel = 1'b1;
    bpu_wb_taken = 1'b1; bpu_wb_hit = 1'b1;
    check("seq wb_ready t", {31'd0, bpu_wb_ready}, 32'd1);
    model_update(30'd20, 1, 1, 1);
    @(negedge clk);                          // t+1
    bpu_wb = 1'b0;
    bpu_rd = 1'b1; bpu_insn_pc = 30'd20; bpu_jmprel = 1'b1;
    check("seq rd_ready t+1", {31'd0, bpu_rd_ready}, 32'd0);
    check("seq wb_ready t+1", {31'd0, bpu_wb_ready}, 32'd0);
    @(negedge clk);                          // t+2
    check("seq rd_ready t+2", {31'd0, bpu_rd_ready}, 32'd0);
    check("seq wb_ready t+2", {31'd0, bpu_wb_ready}, 32'd1);
    check("seq rd_valid t+2", {31'd0, bpu_rd_valid}, 32'd0);
    @(negedge clk);                          // t+3
    check("seq rd_ready t+3", {31'd0, bpu_rd_ready}, 32'd1);
    check("seq rd_valid t+3", {31'd0, bpu_rd_valid}, 32'd0);
    model_lookups++;
    @(negedge clk);                          // t+4: result of t+3 lookup
    bpu_rd = 1'b0;
    check("seq held rd_valid", {31'd0, bpu_rd_valid}, 32'd1);
    check("seq held taken", {31'd0, bpu_jmprel_taken}, 32'd1);  // c=2
    @(negedge clk);
    check("seq rd_valid pulse", {31'd0, bpu_rd_valid}, 32'd0);
    check("seq taken held", {31'd0, bpu_jmprel_taken}, 32'd1);

    // Non-branch update: consumed with no stall.
    @(negedge clk);
    bpu_wb = 1'b1; bpu_wb_insn_pc = 30'd5; bpu_wb_jmprel = 1'b0;
    bpu_wb_taken = 1'b1; bpu_wb_hit = 1'b0;
    @(negedge clk);
    bpu_wb = 1'b0;
    check("nojmp rd_ready", {31'd0, bpu_rd_ready}, 32'd1);
    check("nojmp wb_ready", {31'd0, bpu_wb_ready}, 32'd1);
    do_lookup("nojmp entry5", 30'd5, 1);

    // Simultaneous lookup and update: lookup sees the pre-update value.
    @(negedge clk);
    bpu_rd = 1'b1; bpu_insn_pc = 30'd9; bpu_jmprel = 1'b1;
    bpu_wb = 1'b1; bpu_wb_insn_pc = 30'd9; bpu_wb_jmprel = 1'b1;
    bpu_wb_taken = 1'b1; bpu_wb_hit = 1'b0;
    model_lookups++;
    exp_q.push_back({31'd0, model_cnt[9] >= 2});
    model_update(30'd9, 1, 1, 0);
    @(negedge clk);
    bpu_rd = 1'b0; bpu_wb = 1'b0;
    check("simul rd_valid", {31'd0, bpu_rd_valid}, 32'd1);
    check("simul taken pre", {31'd0, bpu_jmprel_taken}, exp_q.pop_front());
    do_lookup("simul after", 30'd9, 1);
    check_stats("directed");

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic [AW-3:0] pc;
      pc = 30'($urandom);
      if ($urandom_range(0, 3) == 0) pc = 30'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1)
        do_update(pc, $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      else
        do_lookup($sformatf("rand%0d", i), pc, $urandom_range(0, 3) != 0);
    end
    check_stats("random");

    // Async reset while an update is in U_RD; entry 5 driven to 3 first.
    do_reset();
    do_update(30'd5, 1, 1, 1);
    do_update(30'd5, 1, 1, 1);
    @(negedge clk);
    bpu_wb = 1'b1; bpu_wb_insn_pc = 30'd5; bpu_wb_jmprel = 1'b1;
    bpu_wb_taken = 1'b1; bpu_wb_hit = 1'b0;
    @(negedge clk);                          // update now in U_RD
    bpu_wb = 1'b0;
    check("midrst wb_ready in rd", {31'd0, bpu_wb_ready}, 32'd0);
    do_reset();
    do_update(30'd5, 1, 0, 1);               // c=1 -> 0 only if re-swept
    do_lookup("midrst entry5", 30'd5, 1);
    do_update(30'd5, 1, 1, 1);
    do_update(30'd5, 1, 1, 1);               // c=2
    do_lookup("midrst entry5 up", 30'd5, 1);

    // Statistics scenario: 3 branch lookups, 2 mispredicted updates.
    do_reset();
    do_lookup("stat l1", 30'd11, 1);
    do_lookup("stat l2", 30'd12, 1);
    do_lookup("stat l3", 30'd13, 1);
    do_lookup("stat l4 nobr", 30'd13, 0);
    do_update(30'd11, 1, 1, 0);
    do_update(30'd12, 1, 0, 0);
    do_update(30'd13, 1, 1, 1);
    do_update(30'd14, 0, 1, 0);
    @(negedge clk);
    check_stats("stat");
    if (stat_en) begin
      check("stat lookup=3", bpu_stat_lookup, 32'd3);
      check("stat miss=2",   bpu_stat_miss, 32'd2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
